// File: rtl/key_ctrl.sv
// key_ctrl: PS/2 scancode decoder for character movement.
// Turns make/break byte sequences into registered held-key levels
// (stepleft/stepright), a rising-edge jump pulse and a prefix timeout pulse.
// Optional build macro: KEY_CTRL_ARROW_KEYS_EN adds E0-prefixed arrow keys.
module key_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump,
  output logic       key_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  // One held bit per physical key
  localparam int unsigned K_A  = 0;
  localparam int unsigned K_D  = 1;
  localparam int unsigned K_W  = 2;
  localparam int unsigned K_SP = 3;
`ifdef KEY_CTRL_ARROW_KEYS_EN
  localparam int unsigned K_AL = 4;
  localparam int unsigned K_AR = 5;
  localparam int unsigned K_AU = 6;
  localparam int unsigned NK   = 7;
`else
  localparam int unsigned NK   = 4;
`endif

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NK-1:0]   held_q, held_d;
  logic [NK-1:0]   key_mask;
  logic            is_make, is_brk, is_ext;
  logic            left_d, right_d, jump_d, jump_q;
  logic            stepleft_q, stepright_q, stepjump_q, key_err_q;
  logic            err_d;

  // Map the completed code (plain or extended) to its held bit
  always_comb begin
    key_mask = '0;
    if (!is_ext) begin
      case (scan_code)
        8'h1C:   key_mask[K_A]  = 1'b1;
        8'h23:   key_mask[K_D]  = 1'b1;
        8'h1D:   key_mask[K_W]  = 1'b1;
        8'h29:   key_mask[K_SP] = 1'b1;
        default: key_mask = '0;
      endcase
    end
`ifdef KEY_CTRL_ARROW_KEYS_EN
    else begin
      case (scan_code)
        8'h6B:   key_mask[K_AL] = 1'b1;
        8'h74:   key_mask[K_AR] = 1'b1;
        8'h75:   key_mask[K_AU] = 1'b1;
        default: key_mask = '0;
      endcase
    end
`endif
  end

  // Prefix FSM, timeout counter and held-bit update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    err_d   = 1'b0;
    is_make = 1'b0;
    is_brk  = 1'b0;
    is_ext  = 1'b0;
    if (scan_valid) begin
      // A byte always wins over a simultaneous timeout
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (scan_code == 8'hF0)      state_d = BRK;
          else if (scan_code == 8'hE0) state_d = EXT;
          else                         is_make = 1'b1;
        end
        BRK: begin
          if (scan_code != 8'hF0) begin
            is_brk  = 1'b1;
            state_d = IDLE;
          end
        end
        EXT: begin
          if (scan_code == 8'hF0)      state_d = EXT_BRK;
          else if (scan_code != 8'hE0) begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          if (scan_code != 8'hF0) begin
            is_brk  = 1'b1;
            is_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Repeated makes / unheld breaks rewrite the same value
    if (is_make) held_d = held_q | key_mask;
    if (is_brk)  held_d = held_q & ~key_mask;
  end

  // Direction/jump aggregation over next-state and current held bits
  always_comb begin
`ifdef KEY_CTRL_ARROW_KEYS_EN
    left_d  = held_d[K_A] | held_d[K_AL];
    right_d = held_d[K_D] | held_d[K_AR];
    jump_d  = held_d[K_W] | held_d[K_SP] | held_d[K_AU];
    jump_q  = held_q[K_W] | held_q[K_SP] | held_q[K_AU];
`else
    left_d  = held_d[K_A];
    right_d = held_d[K_D];
    jump_d  = held_d[K_W] | held_d[K_SP];
    jump_q  = held_q[K_W] | held_q[K_SP];
`endif
  end

  // State, counter, held bits and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      held_q      <= '0;
      stepleft_q  <= 1'b0;
      stepright_q <= 1'b0;
      stepjump_q  <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      held_q      <= held_d;
      stepleft_q  <= left_d & ~right_d;
      stepright_q <= right_d & ~left_d;
      stepjump_q  <= jump_d & ~jump_q;
      key_err_q   <= err_d;
    end
  end

  assign stepleft  = stepleft_q;
  assign stepright = stepright_q;
  assign stepjump  = stepjump_q;
  assign key_err   = key_err_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Testbench for key_ctrl: directed vector table, hand sequences for the
// timeout/reset/extended corners, and randomized bytes against a
// behavioural model. Build with KEY_CTRL_ARROW_KEYS_EN to test arrow keys.
module tb_key_ctrl;

  localparam int unsigned T = 20;
`ifdef KEY_CTRL_ARROW_KEYS_EN
  localparam bit ARROWS = 1'b1;
`else
  localparam bit ARROWS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       stepleft, stepright, stepjump, key_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  key_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .stepleft  (stepleft),
    .stepright (stepright),
    .stepjump  (stepjump),
    .key_err   (key_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Pending prefix remembered as two flags; keys as a set of held ids.
  bit          m_ext, m_brk;
  bit          m_held[7];
  int unsigned m_idle;
  bit          m_left, m_right, m_jump, m_err;

  function automatic int key_of(bit ext, logic [7:0] c);
    if (!ext) begin
      if (c == 8'h1C) return 0;
      if (c == 8'h23) return 1;
      if (c == 8'h1D) return 2;
      if (c == 8'h29) return 3;
    end else if (ARROWS) begin
      if (c == 8'h6B) return 4;
      if (c == 8'h74) return 5;
      if (c == 8'h75) return 6;
    end
    return -1;
  endfunction

  function automatic bit left_any();  return m_held[0] | m_held[4]; endfunction
  function automatic bit right_any(); return m_held[1] | m_held[5]; endfunction
  function automatic bit jump_any();  return m_held[2] | m_held[3] | m_held[6]; endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_idle = 0;
    foreach (m_held[i]) m_held[i] = 0;
    m_left = 0; m_right = 0; m_jump = 0; m_err = 0;
  endtask

  task automatic model_step(bit v, logic [7:0] c);
    bit pj;
    int k;
    pj = jump_any();
    m_err = 0;
    if (v) begin
      m_idle = 0;
      if (c == 8'hF0) m_brk = 1;
      else if (c == 8'hE0 && !m_brk) m_ext = 1;
      else begin
        k = key_of(m_ext, c);
        if (k >= 0) m_held[k] = !m_brk;
        m_ext = 0;
        m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_idle++;
      if (m_idle == T) begin
        m_ext = 0; m_brk = 0; m_idle = 0; m_err = 1;
      end
    end
    m_left  = left_any() && !right_any();
    m_right = right_any() && !left_any();
    m_jump  = jump_any() && !pj;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(bit v, logic [7:0] c);
    @(negedge clk);
    scan_valid = v;
    scan_code  = c;
    @(posedge clk);
    #1;
    model_step(v, c);
    chk("model_stepleft",  stepleft,  m_left);
    chk("model_stepright", stepright, m_right);
    chk("model_stepjump",  stepjump,  m_jump);
    chk("model_key_err",   key_err,   m_err);
  endtask

  typedef struct {
    bit         v;
    logic [7:0] c;
    bit         l;
    bit         r;
    bit         j;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] pool[11] = '{8'h1C, 8'h23, 8'h1D, 8'h29, 8'h6B, 8'h74,
                           8'h75, 8'hE0, 8'hF0, 8'hFA, 8'hAA};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stepleft",  stepleft,  1'b0);
    chk("reset_stepright", stepright, 1'b0);
    chk("reset_stepjump",  stepjump,  1'b0);
    chk("reset_key_err",   key_err,   1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ---- directed table: {valid, code, left, right, jump}; key_err always 0
    // left held then released
    tbl.push_back('{1, 8'h1C, 1, 0, 0});
    tbl.push_back('{1, 8'hF0, 1, 0, 0});
    tbl.push_back('{1, 8'h1C, 0, 0, 0});
    // both directions cancel, release left leaves right
    tbl.push_back('{1, 8'h1C, 1, 0, 0});
    tbl.push_back('{1, 8'h23, 0, 0, 0});
    tbl.push_back('{1, 8'hF0, 0, 0, 0});
    tbl.push_back('{1, 8'h1C, 0, 1, 0});
    tbl.push_back('{1, 8'hF0, 0, 1, 0});
    tbl.push_back('{1, 8'h23, 0, 0, 0});
    // typematic jump: single pulse, re-press pulses again
    tbl.push_back('{1, 8'h29, 0, 0, 1});
    tbl.push_back('{1, 8'h29, 0, 0, 0});
    tbl.push_back('{1, 8'h29, 0, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 0, 0});
    tbl.push_back('{1, 8'hF0, 0, 0, 0});
    tbl.push_back('{1, 8'h29, 0, 0, 0});
    tbl.push_back('{1, 8'h29, 0, 0, 1});
    tbl.push_back('{0, 8'h00, 0, 0, 0});
    // ignored codes; second jump key while first held gives no pulse
    tbl.push_back('{1, 8'hFA, 0, 0, 0});
    tbl.push_back('{1, 8'hAA, 0, 0, 0});
    tbl.push_back('{1, 8'h1D, 0, 0, 0});
    tbl.push_back('{1, 8'hF0, 0, 0, 0});
    tbl.push_back('{1, 8'h29, 0, 0, 0});
    tbl.push_back('{1, 8'hF0, 0, 0, 0});
    tbl.push_back('{1, 8'h1D, 0, 0, 0});
    tbl.push_back('{1, 8'h1D, 0, 0, 1});
    tbl.push_back('{1, 8'hF0, 0, 0, 0});
    tbl.push_back('{1, 8'h1D, 0, 0, 0});
    // break of unheld key, repeat make of held key
    tbl.push_back('{1, 8'hF0, 0, 0, 0});
    tbl.push_back('{1, 8'h23, 0, 0, 0});
    tbl.push_back('{1, 8'h23, 0, 1, 0});
    tbl.push_back('{1, 8'h23, 0, 1, 0});
    tbl.push_back('{1, 8'hF0, 0, 1, 0});
    tbl.push_back('{1, 8'h23, 0, 0, 0});

    foreach (tbl[i]) begin
      tick(tbl[i].v, tbl[i].c);
      chk($sformatf("vec%0d_stepleft", i),  stepleft,  tbl[i].l);
      chk($sformatf("vec%0d_stepright", i), stepright, tbl[i].r);
      chk($sformatf("vec%0d_stepjump", i),  stepjump,  tbl[i].j);
      chk($sformatf("vec%0d_key_err", i),   key_err,   1'b0);
    end

    // ---- E0 then T idle cycles: one key_err, back in IDLE
    tick(1, 8'hE0);
    for (int unsigned i = 0; i < T - 1; i++) begin
      tick(0, 8'h00);
      chk("timeout_early_err", key_err, 1'b0);
    end
    tick(0, 8'h00);
    chk("timeout_err", key_err, 1'b1);
    tick(0, 8'h00);
    chk("timeout_err_one_cycle", key_err, 1'b0);
    tick(1, 8'h23);
    chk("timeout_then_right", stepright, 1'b1);
    tick(1, 8'hF0);
    tick(1, 8'h23);

    // ---- byte on the timeout cycle wins and restarts the count
    tick(1, 8'hE0);
    for (int unsigned i = 0; i < T - 1; i++) tick(0, 8'h00);
    tick(1, 8'hF0);
    chk("collide_no_err", key_err, 1'b0);
    for (int unsigned i = 0; i < T - 1; i++) begin
      tick(0, 8'h00);
      chk("collide_restart_err", key_err, 1'b0);
    end
    tick(0, 8'h00);
    chk("collide_late_err", key_err, 1'b1);

    // ---- extended left arrow
    tick(1, 8'hE0);
    tick(1, 8'h6B);
    chk("arrow_left", stepleft, ARROWS);
    tick(1, 8'h1C);
    chk("arrow_then_a", stepleft, 1'b1);
    tick(1, 8'hF0);
    tick(1, 8'h1C);
    chk("arrow_after_a_release", stepleft, ARROWS);
    tick(1, 8'hE0);
    tick(1, 8'hF0);
    tick(1, 8'h6B);
    chk("arrow_release", stepleft, 1'b0);

    // ---- reset after E0 discards prefix and held bits
    tick(1, 8'h1C);
    chk("pre_reset_left", stepleft, 1'b1);
    tick(1, 8'hE0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_stepleft",  stepleft,  1'b0);
    chk("async_rst_stepright", stepright, 1'b0);
    chk("async_rst_stepjump",  stepjump,  1'b0);
    chk("async_rst_key_err",   key_err,   1'b0);
    model_reset();
    #1;
    rst = 1'b0;
    tick(1, 8'h6B);
    chk("post_rst_6b_left", stepleft, 1'b0);
    chk("post_rst_6b_err",  key_err,  1'b0);
    tick(1, 8'h1C);
    chk("post_rst_a_left", stepleft, 1'b1);
    tick(1, 8'hF0);
    tick(1, 8'h1C);

    // ---- randomized bytes against the model
    for (int unsigned n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        int unsigned gap;
        gap = $urandom_range(T - 3, T + 3);
        for (int unsigned g = 0; g < gap; g++) tick(0, 8'h00);
      end else if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 9) == 0) tick(1, 8'($urandom));
        else tick(1, pool[$urandom_range(0, 10)]);
      end else begin
        tick(0, 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
